// File: rtl/knn_pkg.sv
// -----------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the KNN top-K selection and voting engine:
//   - state_t  : voting engine FSM states
//   - DIST_MAX : all-ones distance used for empty list entries (sliced to DIST_W)
//   - vote_w() : width of a vote count able to hold 0..K
// -----------------------------------------------------------------------------
package knn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_t;

  // Wide enough for any supported DIST_W; users take the low DIST_W bits.
  localparam int          DIST_MAX_W = 64;
  localparam logic [63:0] DIST_MAX   = 64'hFFFF_FFFF_FFFF_FFFF;

  // Number of bits needed to count 0..k votes (also used for list indices 0..k).
  function automatic int vote_w(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/knn_topk_list.sv
// -----------------------------------------------------------------------------
// knn_topk_list
// K-entry ascending sorted buffer of (distance, label) pairs. An insert is
// completed in one cycle by a parallel compare-and-shift: every entry that is
// empty or strictly larger than the new distance moves down one slot and the
// new pair lands in the first such slot. Equal distances therefore keep their
// arrival order. A sample that finds no such slot (list full, all smaller or
// equal) is dropped.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        synchronous clear: all entries invalid, distance all-ones
//   i_insert       insert (i_dist, i_label) this cycle
//   o_valid        per-entry valid vector (valid entries form a prefix)
//   o_label        per-entry labels
//   o_head_dist    distance of entry 0 (smallest; all-ones when empty)
// -----------------------------------------------------------------------------
module knn_topk_list
  import knn_pkg::*;
#(
  parameter int K       = 5,
  parameter int DIST_W  = 16,
  parameter int LABEL_W = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_insert,
  input  logic [DIST_W-1:0]           i_dist,
  input  logic [LABEL_W-1:0]          i_label,
  output logic [K-1:0]                o_valid,
  output logic [K-1:0][LABEL_W-1:0]   o_label,
  output logic [DIST_W-1:0]           o_head_dist
);

  logic [K-1:0]               r_valid;
  logic [K-1:0][DIST_W-1:0]   r_dist;
  logic [K-1:0][LABEL_W-1:0]  r_label;

  logic [K-1:0]               w_gt;
  logic [K-1:0]               w_prev_gt;
  logic [K-1:0]               w_valid_sh;
  logic [K-1:0][DIST_W-1:0]   w_dist_sh;
  logic [K-1:0][LABEL_W-1:0]  w_label_sh;

  // Per-entry "new sample sorts before this entry" flags.
  always_comb begin
    w_gt = '0;
    for (int i = 0; i < K; i++) begin
      w_gt[i] = !r_valid[i] || (r_dist[i] > i_dist);
    end
  end

  // Entry i-1 viewed from slot i; slot 0 sees nothing above it.
  assign w_prev_gt  = w_gt << 1;
  assign w_valid_sh = r_valid << 1;
  assign w_dist_sh  = r_dist << DIST_W;
  assign w_label_sh = r_label << LABEL_W;

  // Sorted entry storage: clear, or one-cycle insert with shift-down.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_label <= '0;
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= DIST_MAX[DIST_W-1:0];
      end
    end else if (i_clear) begin
      r_valid <= '0;
      r_label <= '0;
      for (int i = 0; i < K; i++) begin
        r_dist[i] <= DIST_MAX[DIST_W-1:0];
      end
    end else if (i_insert) begin
      for (int i = 0; i < K; i++) begin
        if (w_gt[i] && !w_prev_gt[i]) begin
          // First slot the new sample beats: it goes here.
          r_valid[i] <= 1'b1;
          r_dist[i]  <= i_dist;
          r_label[i] <= i_label;
        end else if (w_gt[i]) begin
          // Below the insertion point: take the entry above.
          r_valid[i] <= w_valid_sh[i];
          r_dist[i]  <= w_dist_sh[i];
          r_label[i] <= w_label_sh[i];
        end
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_label     = r_label;
  assign o_head_dist = r_dist[0];

endmodule

// File: rtl/knn_topk_vote.sv
// -----------------------------------------------------------------------------
// knn_topk_vote
// KNN selection and voting engine. A frame opens with start, collects a
// stream of (distance, label) samples into a K-entry sorted list, then scans
// classes 0..NUM_CLASSES-1 one per cycle to find the majority class among the
// kept entries, and presents the result until it is accepted.
//
// Ports:
//   clk_en, reset        clock, asynchronous active-high reset
//   start                opens a frame (IDLE only)
//   dist_valid/ready     sample handshake; dist_ready high only in COLLECT
//   dist_data/label/last sample distance, class, end-of-frame marker
//   result_valid/ready   result handshake; result held until accepted
//   result_label         winning class
//   result_votes         votes of the winning class
//   result_min_dist      smallest kept distance (all-ones if none kept)
//   busy                 high whenever the engine is not IDLE
// -----------------------------------------------------------------------------
module knn_topk_vote
  import knn_pkg::*;
#(
  parameter int K           = 5,
  parameter int DIST_W      = 16,
  parameter int LABEL_W     = 4,
  parameter int NUM_CLASSES = 10,
  parameter int TIE_NEAREST = 1
) (
  input  logic                    clk_en,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    dist_valid,
  output logic                    dist_ready,
  input  logic [DIST_W-1:0]       dist_data,
  input  logic [LABEL_W-1:0]      dist_label,
  input  logic                    dist_last,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [LABEL_W-1:0]      result_label,
  output logic [vote_w(K)-1:0]    result_votes,
  output logic [DIST_W-1:0]       result_min_dist,
  output logic                    busy
);

  localparam int                 VOTE_W     = vote_w(K);
  localparam int                 IDX_W      = vote_w(K);
  localparam logic [IDX_W-1:0]   IDX_NONE   = IDX_W'(K);
  localparam logic [LABEL_W-1:0] LAST_CLASS = LABEL_W'(NUM_CLASSES - 1);
  localparam logic [LABEL_W:0]   NUM_CLS_L  = (LABEL_W + 1)'(NUM_CLASSES);

  state_t                     r_state;
  logic [LABEL_W-1:0]         r_class;
  logic [LABEL_W-1:0]         r_best_label;
  logic [VOTE_W-1:0]          r_best_cnt;
  logic [IDX_W-1:0]           r_best_first;
  logic [LABEL_W-1:0]         r_res_label;
  logic [VOTE_W-1:0]          r_res_votes;
  logic [DIST_W-1:0]          r_res_min;

  logic                       w_clear;
  logic                       w_insert;
  logic                       w_in_range;
  logic [K-1:0]               w_valid;
  logic [K-1:0][LABEL_W-1:0]  w_label;
  logic [DIST_W-1:0]          w_head_dist;
  logic [K-1:0]               w_match;
  logic [VOTE_W-1:0]          w_cnt;
  logic [IDX_W-1:0]           w_first;
  logic                       w_take;
  logic [LABEL_W-1:0]         w_next_label;
  logic [VOTE_W-1:0]          w_next_cnt;
  logic [IDX_W-1:0]           w_next_first;

  // Labels outside 0..NUM_CLASSES-1 are consumed but never stored.
  assign w_in_range = ({1'b0, dist_label} < NUM_CLS_L);
  assign w_clear    = (r_state == ST_IDLE) && start;
  assign w_insert   = (r_state == ST_COLLECT) && dist_valid && w_in_range;

  knn_topk_list #(
    .K       (K),
    .DIST_W  (DIST_W),
    .LABEL_W (LABEL_W)
  ) u_list (
    .i_clk       (clk_en),
    .i_rst       (reset),
    .i_clear     (w_clear),
    .i_insert    (w_insert),
    .i_dist      (dist_data),
    .i_label     (dist_label),
    .o_valid     (w_valid),
    .o_label     (w_label),
    .o_head_dist (w_head_dist)
  );

  // Entries that belong to the class currently being scanned.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < K; i++) begin
      w_match[i] = w_valid[i] && (w_label[i] == r_class);
    end
  end

  // Vote count and lowest (nearest) list index for the scanned class.
  always_comb begin
    w_cnt   = '0;
    w_first = IDX_NONE;
    for (int i = K - 1; i >= 0; i--) begin
      w_cnt   = w_cnt + VOTE_W'(w_match[i]);
      w_first = w_match[i] ? IDX_W'(i) : w_first;
    end
  end

  // Does the scanned class displace the running best?
  always_comb begin
    if (w_cnt > r_best_cnt) begin
      w_take = 1'b1;
    end else if ((w_cnt == r_best_cnt) && (w_cnt != '0)) begin
      // Equal non-zero count: nearest-entry mode prefers the class whose
      // first entry sits higher in the list; otherwise the lower class
      // (already held) stays.
      w_take = (TIE_NEAREST != 0) && (w_first < r_best_first);
    end else begin
      w_take = 1'b0;
    end
  end

  assign w_next_label = w_take ? r_class : r_best_label;
  assign w_next_cnt   = w_take ? w_cnt   : r_best_cnt;
  assign w_next_first = w_take ? w_first : r_best_first;

  // Engine FSM: frame collection, class scan and held result.
  always_ff @(posedge clk_en or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_class      <= '0;
      r_best_label <= '0;
      r_best_cnt   <= '0;
      r_best_first <= IDX_NONE;
      r_res_label  <= '0;
      r_res_votes  <= '0;
      r_res_min    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (dist_valid && dist_last) begin
            r_state      <= ST_VOTE;
            r_class      <= '0;
            r_best_label <= '0;
            r_best_cnt   <= '0;
            r_best_first <= IDX_NONE;
          end
        end
        ST_VOTE: begin
          r_best_label <= w_next_label;
          r_best_cnt   <= w_next_cnt;
          r_best_first <= w_next_first;
          r_class      <= r_class + LABEL_W'(1);
          if (r_class == LAST_CLASS) begin
            // Last class folds straight into the result registers.
            r_state     <= ST_OUTPUT;
            r_res_label <= w_next_label;
            r_res_votes <= w_next_cnt;
            r_res_min   <= w_head_dist;
          end
        end
        ST_OUTPUT: begin
          if (result_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dist_ready      = (r_state == ST_COLLECT);
  assign result_valid    = (r_state == ST_OUTPUT);
  assign busy            = (r_state != ST_IDLE);
  assign result_label    = r_res_label;
  assign result_votes    = r_res_votes;
  assign result_min_dist = r_res_min;

endmodule

// File: tb/tb_knn_topk_vote.sv
// -----------------------------------------------------------------------------
// tb_knn_topk_vote
// Four engines with different K / tie-break settings are driven by one shared
// stimulus stream. A reference model (select the K smallest in-range samples,
// earlier arrival first on equal distance, then count classes) predicts each
// engine's result; a per-cycle monitor compares handshake and result outputs.
// Hand-computed literals pin both the model and the engines.
// -----------------------------------------------------------------------------
module tb_knn_topk_vote;

  localparam int ND = 4;
  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        dist_valid;
  logic [15:0] dist_data;
  logic [3:0]  dist_label;
  logic        dist_last;
  logic        result_ready;

  logic        rdy [ND];
  logic        rv  [ND];
  logic        bsy [ND];
  logic [3:0]  lab [ND];
  logic [2:0]  vts [ND];
  logic [15:0] mn  [ND];
  logic [1:0]  v0;
  logic [2:0]  v1;
  logic [2:0]  v2;
  logic        v3;

  int tests = 0;
  int fails = 0;
  int phase = 0;      // 0 idle, 1 collecting, 2 voting / result pending
  bit chk_en = 1'b0;
  bit res_seen = 1'b0;
  int exp_lab   [ND];
  int exp_votes [ND];
  int exp_min   [ND];
  int q_d [$];
  int q_l [$];

  always #5 clk = ~clk;

  assign vts[0] = {1'b0, v0};
  assign vts[1] = v1;
  assign vts[2] = v2;
  assign vts[3] = {2'b00, v3};

  knn_topk_vote #(.K(3), .DIST_W(16), .LABEL_W(4), .NUM_CLASSES(NC), .TIE_NEAREST(1)) u0 (
    .clk_en(clk), .reset(reset), .start(start), .dist_valid(dist_valid), .dist_ready(rdy[0]),
    .dist_data(dist_data), .dist_label(dist_label), .dist_last(dist_last),
    .result_valid(rv[0]), .result_ready(result_ready), .result_label(lab[0]),
    .result_votes(v0), .result_min_dist(mn[0]), .busy(bsy[0]));

  knn_topk_vote #(.K(4), .DIST_W(16), .LABEL_W(4), .NUM_CLASSES(NC), .TIE_NEAREST(1)) u1 (
    .clk_en(clk), .reset(reset), .start(start), .dist_valid(dist_valid), .dist_ready(rdy[1]),
    .dist_data(dist_data), .dist_label(dist_label), .dist_last(dist_last),
    .result_valid(rv[1]), .result_ready(result_ready), .result_label(lab[1]),
    .result_votes(v1), .result_min_dist(mn[1]), .busy(bsy[1]));

  knn_topk_vote #(.K(4), .DIST_W(16), .LABEL_W(4), .NUM_CLASSES(NC), .TIE_NEAREST(0)) u2 (
    .clk_en(clk), .reset(reset), .start(start), .dist_valid(dist_valid), .dist_ready(rdy[2]),
    .dist_data(dist_data), .dist_label(dist_label), .dist_last(dist_last),
    .result_valid(rv[2]), .result_ready(result_ready), .result_label(lab[2]),
    .result_votes(v2), .result_min_dist(mn[2]), .busy(bsy[2]));

  knn_topk_vote #(.K(1), .DIST_W(16), .LABEL_W(4), .NUM_CLASSES(NC), .TIE_NEAREST(1)) u3 (
    .clk_en(clk), .reset(reset), .start(start), .dist_valid(dist_valid), .dist_ready(rdy[3]),
    .dist_data(dist_data), .dist_label(dist_label), .dist_last(dist_last),
    .result_valid(rv[3]), .result_ready(result_ready), .result_label(lab[3]),
    .result_votes(v3), .result_min_dist(mn[3]), .busy(bsy[3]));

  function automatic int k_of(input int d);
    case (d)
      0: return 3;
      1: return 4;
      2: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int tie_of(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  // Reference: pick the k smallest in-range samples (earliest wins equal
  // distances), then majority vote with the configured tie-break.
  function automatic void model(input int k, input int tie, output int o_lab,
                                output int o_votes, output int o_min);
    bit taken [64];
    int sel [$];
    int cnt [16];
    int first [16];
    int mx;
    for (int r = 0; r < k; r++) begin
      int best = -1;
      for (int j = 0; j < q_d.size(); j++) begin
        if (!taken[j] && q_l[j] < NC && (best < 0 || q_d[j] < q_d[best])) best = j;
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        sel.push_back(best);
      end
    end
    for (int c = 0; c < 16; c++) begin
      cnt[c] = 0;
      first[c] = 99;
    end
    for (int p = 0; p < sel.size(); p++) begin
      cnt[q_l[sel[p]]]++;
      if (first[q_l[sel[p]]] == 99) first[q_l[sel[p]]] = p;
    end
    mx = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > mx) mx = cnt[c];
    o_lab = 0;
    o_votes = mx;
    o_min = (sel.size() > 0) ? q_d[sel[0]] : 65535;
    if (mx > 0) begin
      int bf = 100;
      for (int c = NC - 1; c >= 0; c--) begin
        if (cnt[c] == mx) begin
          if (tie == 0) o_lab = c;
          else if (first[c] <= bf) begin
            bf = first[c];
            o_lab = c;
          end
        end
      end
    end
  endfunction

  task automatic check(input string nm, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, act, exp);
    end
  endtask

  task automatic compute_expected();
    int l, v, m;
    for (int d = 0; d < ND; d++) begin
      model(k_of(d), tie_of(d), l, v, m);
      exp_lab[d] = l;
      exp_votes[d] = v;
      exp_min[d] = m;
    end
  endtask

  // Per-cycle monitor of handshake state and held results.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check("busy", d, int'(bsy[d]), (phase != 0) ? 1 : 0);
        check("dist_ready", d, int'(rdy[d]), (phase == 1) ? 1 : 0);
        if (phase != 2) check("result_valid_idle", d, int'(rv[d]), 0);
        else if (res_seen) check("result_valid_held", d, int'(rv[d]), 1);
        if (rv[d]) begin
          check("result_label", d, int'(lab[d]), exp_lab[d]);
          check("result_votes", d, int'(vts[d]), exp_votes[d]);
          check("result_min_dist", d, int'(mn[d]), exp_min[d]);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      check({tag, "_dist_ready"}, d, int'(rdy[d]), 0);
      check({tag, "_result_valid"}, d, int'(rv[d]), 0);
      check({tag, "_busy"}, d, int'(bsy[d]), 0);
      check({tag, "_label"}, d, int'(lab[d]), 0);
      check({tag, "_votes"}, d, int'(vts[d]), 0);
      check({tag, "_min_dist"}, d, int'(mn[d]), 0);
    end
  endtask

  task automatic do_start();
    q_d.delete();
    q_l.delete();
    start = 1'b1;
    @(posedge clk);
    phase = 1;
    #1 start = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = rv[0];
    end
    check("result_latency", 0, n, NC + 1);
    for (int d = 1; d < ND; d++) check("result_valid_together", d, int'(rv[d]), 1);
    res_seen = 1'b1;
  endtask

  task automatic send(input int dd, input int ll, input bit last);
    dist_valid = 1'b1;
    dist_data  = 16'(dd);
    dist_label = 4'(ll);
    dist_last  = last;
    @(posedge clk);
    q_d.push_back(dd);
    q_l.push_back(ll);
    if (last) begin
      compute_expected();
      phase = 2;
    end
    #1;
    dist_valid = 1'b0;
    dist_last  = 1'b0;
    if (last) wait_result();
  endtask

  task automatic take_result(input bit with_start);
    result_ready = 1'b1;
    start = with_start;
    @(posedge clk);
    phase = 0;
    res_seen = 1'b0;
    #1;
    result_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("busy_after_handshake", d, int'(bsy[d]), 0);
  endtask

  task automatic pin(input int d, input int l, input int v, input int m);
    check("model_label", d, exp_lab[d], l);
    check("model_votes", d, exp_votes[d], v);
    check("model_min_dist", d, exp_min[d], m);
    check("lit_label", d, int'(lab[d]), l);
    check("lit_votes", d, int'(vts[d]), v);
    check("lit_min_dist", d, int'(mn[d]), m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dist_valid = 1'b0;
    dist_data = 16'd0;
    dist_label = 4'd0;
    dist_last = 1'b0;
    result_ready = 1'b0;
    #3 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Mixed frame, more samples than K.
    do_start();
    send(50, 2, 1'b0); send(10, 7, 1'b0); send(30, 7, 1'b0); send(20, 1, 1'b0); send(40, 2, 1'b1);
    pin(0, 7, 2, 10);
    take_result(1'b0);

    // Two-way tie, both tie-break modes.
    do_start();
    send(5, 3, 1'b0); send(6, 3, 1'b0); send(7, 1, 1'b0); send(8, 1, 1'b1);
    pin(1, 3, 2, 5);
    pin(2, 1, 2, 5);
    take_result(1'b0);

    // Single sample.
    do_start();
    send(100, 4, 1'b1);
    pin(0, 4, 1, 100);
    take_result(1'b0);

    // Equal distances: earlier arrival kept.
    do_start();
    send(10, 2, 1'b0); send(10, 5, 1'b1);
    pin(3, 2, 1, 10);
    pin(0, 2, 1, 10);
    take_result(1'b0);

    // Only out-of-range labels.
    do_start();
    send(7, 12, 1'b0); send(9, 15, 1'b1);
    for (int d = 0; d < ND; d++) pin(d, 0, 0, 65535);
    take_result(1'b0);

    // Longer frame with duplicates and discards.
    do_start();
    send(9, 1, 1'b0); send(3, 2, 1'b0); send(3, 3, 1'b0); send(12, 2, 1'b0);
    send(1, 4, 1'b0); send(3, 1, 1'b0); send(20, 5, 1'b0); send(2, 2, 1'b1);
    pin(1, 2, 2, 1);
    take_result(1'b0);

    // Result backpressure with start pulses that must be ignored.
    do_start();
    send(1, 9, 1'b0); send(2, 9, 1'b0); send(3, 0, 1'b1);
    pin(0, 9, 2, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c % 5 == 0);
    end
    start = 1'b0;
    take_result(1'b1);

    // Reset in the middle of collection.
    do_start();
    send(4, 8, 1'b0); send(2, 8, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    phase = 0;
    #1 check_zero("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    do_start();
    send(3, 6, 1'b1);
    for (int d = 0; d < ND; d++) pin(d, 6, 1, 3);
    take_result(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
